// File: rtl/pc_select_unit.sv
// Program counter and next-PC selector: sequential fetch, branch, jr/jalr and J-type redirects,
// plus IF flush strobe, sticky misaligned-jr flag and a saturating redirect counter.
module pc_select_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic [1:0]        JumpOP,
  input  logic [ADDR_W-1:0] BranchAddr,
  input  logic [ADDR_W-1:0] JrAddr,
  input  logic [25:0]       JumpIndex,
  input  logic [ADDR_W-1:0] ID_PC4,
  output logic [ADDR_W-1:0] PCout,
  output logic [ADDR_W-1:0] PC4out,
  output logic              IF_Flush,
  output logic              AddrErr,
  output logic [CNT_W-1:0]  RedirectCnt
);

  typedef enum logic [1:0] {
    JSEQ = 2'b00,
    JBR  = 2'b01,
    JREG = 2'b10,
    JJMP = 2'b11
  } jumpOp_e;

  jumpOp_e          op;
  logic             redirect;
  logic             misaligned;
  logic [ADDR_W-1:0] jTarget;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] nextPc;
  logic             unusedPc4Low;

  assign op         = jumpOp_e'(JumpOP);
  assign redirect   = (op != JSEQ);
  assign misaligned = (op == JREG) && (JrAddr[1:0] != 2'b00);
  assign IF_Flush   = redirect;
  assign PC4out     = PCout + ADDR_W'(4);

  // J-type keeps the region bits of the jump's own PC+4; only meaningful above bit 27.
  if (ADDR_W > 28) begin : gRegion
    assign jTarget = {ID_PC4[ADDR_W-1:28], JumpIndex, 2'b00};
  end else begin : gNoRegion
    assign jTarget = {JumpIndex, 2'b00};
  end
  assign unusedPc4Low = ^ID_PC4[27:0];

  always_comb begin
    target = PC4out;
    case (op)
      JBR:     target = BranchAddr;
      JREG:    target = {JrAddr[ADDR_W-1:2], 2'b00};
      JJMP:    target = jTarget;
      default: target = PC4out;
    endcase
  end

  // A redirect wins over a load-use stall; the stalled fetch is squashed by IF_Flush.
  always_comb begin
    nextPc = PCout;
    if (redirect)     nextPc = target;
    else if (PCWrite) nextPc = PC4out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PCout       <= RESET_PC;
      AddrErr     <= 1'b0;
      RedirectCnt <= '0;
    end else begin
      PCout <= nextPc;
      if (misaligned) AddrErr <= 1'b1;
      if (redirect && (RedirectCnt != '1)) RedirectCnt <= RedirectCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_select_unit.sv
// Bench for pc_select_unit: directed vector table, async reset corners, CNT_W=2 saturation,
// and random traffic checked against an arithmetic reference model.
module tb_pc_select_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite;
  logic [1:0]  JumpOP;
  logic [31:0] BranchAddr, JrAddr, ID_PC4;
  logic [25:0] JumpIndex;
  logic [31:0] PCout, PC4out;
  logic        IF_Flush, AddrErr;
  logic [15:0] RedirectCnt;
  logic [31:0] pcOut2, pc4Out2;
  logic        flush2, err2;
  logic [1:0]  cnt2;

  int tests = 0;
  int fails = 0;

  // reference state
  logic [31:0] mPc;
  logic        mErr;
  int          mCnt, mCnt2;

  always #5 clk = ~clk;

  pc_select_unit #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .JumpOP(JumpOP), .BranchAddr(BranchAddr),
    .JrAddr(JrAddr), .JumpIndex(JumpIndex), .ID_PC4(ID_PC4), .PCout(PCout), .PC4out(PC4out),
    .IF_Flush(IF_Flush), .AddrErr(AddrErr), .RedirectCnt(RedirectCnt));

  pc_select_unit #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .JumpOP(JumpOP), .BranchAddr(BranchAddr),
    .JrAddr(JrAddr), .JumpIndex(JumpIndex), .ID_PC4(ID_PC4), .PCout(pcOut2), .PC4out(pc4Out2),
    .IF_Flush(flush2), .AddrErr(err2), .RedirectCnt(cnt2));

  typedef struct {
    logic [1:0]  op;
    logic        pcw;
    logic [31:0] br;
    logic [31:0] jr;
    logic [25:0] idx;
    logic [31:0] idPc4;
    logic [31:0] expPc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc = 32'h0; mErr = 1'b0; mCnt = 0; mCnt2 = 0;
  endtask

  function automatic logic [31:0] refTarget();
    logic [31:0] t;
    case (JumpOP)
      2'd1:    t = BranchAddr;
      2'd2:    t = JrAddr - (JrAddr % 4);
      2'd3:    t = (ID_PC4 & 32'hF000_0000) + 32'(JumpIndex) * 4;
      default: t = mPc + 32'd4;
    endcase
    return t;
  endfunction

  // Called with inputs already applied, away from the clock edge; returns at posedge+1.
  task automatic cycle();
    logic [31:0] e4, nPc;
    #1;
    e4 = mPc + 32'd4;
    chk("if_flush", IF_Flush, (JumpOP != 2'd0));
    chk("pc4out", PC4out, e4);
    nPc = mPc;
    if (JumpOP != 2'd0)  nPc = refTarget();
    else if (PCWrite)    nPc = e4;
    @(posedge clk); #1;
    if (JumpOP == 2'd2 && JrAddr[1:0] != 2'd0) mErr = 1'b1;
    if (JumpOP != 2'd0) begin
      if (mCnt < 65535) mCnt++;
      if (mCnt2 < 3) mCnt2++;
    end
    mPc = nPc;
    chk("pcout", PCout, mPc);
    chk("addr_err", AddrErr, mErr);
    chk("redirect_cnt", RedirectCnt, 64'(mCnt));
    chk("pcout_cnt2", pcOut2, mPc);
    chk("redirect_cnt2", cnt2, 64'(mCnt2));
  endtask

  task automatic setIn(input logic [1:0] op, input logic pcw, input logic [31:0] br,
                       input logic [31:0] jr, input logic [25:0] idx, input logic [31:0] idPc4);
    JumpOP = op; PCWrite = pcw; BranchAddr = br; JrAddr = jr; JumpIndex = idx; ID_PC4 = idPc4;
  endtask

  task automatic fullReset();
    rst = 1'b0;
    #1;
    modelReset();
    chk("rst_pc", PCout, 32'h0);
    chk("rst_err", AddrErr, 1'b0);
    chk("rst_cnt", RedirectCnt, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int cnt2Exp[5];
    cnt2Exp = '{1, 2, 3, 3, 3};
    setIn(2'd0, 1'b1, 32'h0, 32'h0, 26'h0, 32'h0);
    fullReset();

    // directed table; junk fields set where the selected path must ignore them
    tbl.push_back('{2'd0, 1'b1, 32'h0,        32'h0,        26'h0,  32'h0,         32'h4});
    tbl.push_back('{2'd0, 1'b1, 32'h0,        32'h0,        26'h0,  32'h0,         32'h8});
    tbl.push_back('{2'd0, 1'b1, 32'h0,        32'h0,        26'h0,  32'h0,         32'hC});
    tbl.push_back('{2'd0, 1'b1, 32'h0,        32'h0,        26'h0,  32'h0,         32'h10});
    tbl.push_back('{2'd1, 1'b1, 32'h40,       32'h0,        26'h0,  32'h0,         32'h40});
    tbl.push_back('{2'd0, 1'b0, 32'h0,        32'h0,        26'h0,  32'h0,         32'h40});
    tbl.push_back('{2'd0, 1'b0, 32'h0,        32'h0,        26'h0,  32'h0,         32'h40});
    tbl.push_back('{2'd0, 1'b1, 32'h0,        32'h0,        26'h0,  32'h0,         32'h44});
    tbl.push_back('{2'd1, 1'b1, 32'h40,       32'h0,        26'h0,  32'h0,         32'h40});
    tbl.push_back('{2'd1, 1'b0, 32'h100,      32'h0,        26'h0,  32'h0,         32'h100});
    tbl.push_back('{2'd3, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 26'h40, 32'h9000_0010, 32'h9000_0100});
    tbl.push_back('{2'd2, 1'b1, 32'h0,        32'h2003,     26'h0,  32'h0,         32'h2000});
    tbl.push_back('{2'd1, 1'b0, 32'h300,      32'h7,        26'h0,  32'h0,         32'h300});
    tbl.push_back('{2'd2, 1'b1, 32'h0,        32'h400,      26'h0,  32'h0,         32'h400});
    tbl.push_back('{2'd3, 1'b1, 32'h1,        32'h3,        26'h1,  32'h0FFF_FFFF, 32'h4});

    foreach (tbl[i]) begin
      setIn(tbl[i].op, tbl[i].pcw, tbl[i].br, tbl[i].jr, tbl[i].idx, tbl[i].idPc4);
      cycle();
      chk($sformatf("tbl%0d_pc", i), PCout, tbl[i].expPc);
    end
    chk("err_sticky", AddrErr, 1'b1);
    chk("cnt_after_tbl", RedirectCnt, 16'd8);

    // reset asserted mid-redirect acts without a clock edge; first edge after release is normal
    setIn(2'd1, 1'b1, 32'h500, 32'h0, 26'h0, 32'h0);
    #2;
    chk("midrst_flush", IF_Flush, 1'b1);
    rst = 1'b0;
    #1;
    modelReset();
    chk("midrst_pc", PCout, 32'h0);
    chk("midrst_err", AddrErr, 1'b0);
    chk("midrst_cnt", RedirectCnt, 16'h0);
    @(posedge clk); #1;
    chk("midrst_hold_pc", PCout, 32'h0);
    rst = 1'b1;
    cycle();
    chk("post_rst_pc", PCout, 32'h500);

    // narrow counter saturation, then sequential wrap at the top of the address space
    fullReset();
    for (int i = 0; i < 5; i++) begin
      setIn(2'd1, 1'b0, 32'h1000 + 32'(i) * 16, 32'h0, 26'h0, 32'h0);
      cycle();
      chk($sformatf("sat_cnt2_%0d", i), cnt2, 64'(cnt2Exp[i]));
    end
    setIn(2'd1, 1'b1, 32'hFFFF_FFFC, 32'h0, 26'h0, 32'h0);
    cycle();
    chk("wrap_pc4", PC4out, 32'h0);
    setIn(2'd0, 1'b1, 32'h0, 32'h0, 26'h0, 32'h0);
    cycle();
    chk("wrap_pc", PCout, 32'h0);
    chk("wrap_err", AddrErr, 1'b0);

    // random traffic against the model, with occasional async resets
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      setIn(op, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
            26'($urandom), $urandom);
      if ($urandom_range(0, 29) == 0) BranchAddr = 32'hFFFF_FFF8;
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        chk("rnd_rst_pc", PCout, 32'h0);
        chk("rnd_rst_err", AddrErr, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
